sr_latch_driver: RTL



---
 rtl/sr_latch_driver_pkg.sv | 27 ++
 rtl/sr_latch_driver_sync2.sv | 25 ++
 rtl/sr_latch_driver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the gated SR latch sequencer.
// State encoding, legal op codes and error codes reported on err_code.
package sr_latch_driver_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        CHECK = 3'd4,
        OK    = 3'd5,
        FAIL  = 3'd6
    } state_t;

    localparam logic [1:0] OP_RESET    = 2'b01;
    localparam logic [1:0] OP_SET      = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_INVALID = 2'b11;

    function automatic logic op_legal(input logic [1:0] op);
        return (op == OP_RESET) || (op == OP_SET);
    endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset (reset value 0),
// used for latch readback that is not already in the clk domain.
module sr_latch_driver_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Sequencer driving a gated SR latch: setup, enable pulse, release, readback.
// Define SR_LATCH_DRIVER_SYNC_EN to pass q_in/qbar_in through 2-flop synchronizers.
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    output logic       s,
    output logic       r,
    output logic       control,
    input  logic       q_in,
    input  logic       qbar_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

`ifdef SR_LATCH_DRIVER_SYNC_EN
    localparam int CHK_WIN = TIMEOUT + 2;
`else
    localparam int CHK_WIN = TIMEOUT;
`endif

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] CHK_LD   = CNT_W'(CHK_WIN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op_set;
    logic             r_s;
    logic             r_r;
    logic             r_ctrl;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic w_q;
    logic w_qbar;
    logic w_pass;
    logic w_cnt_zero;

`ifdef SR_LATCH_DRIVER_SYNC_EN
    sr_latch_driver_sync2 u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (q_in),
        .o_q   (w_q)
    );

    sr_latch_driver_sync2 u_sync_qbar (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (qbar_in),
        .o_q   (w_qbar)
    );
`else
    assign w_q    = q_in;
    assign w_qbar = qbar_in;
`endif

    assign w_pass     = (w_q == r_op_set) && (w_qbar == ~r_op_set);
    assign w_cnt_zero = (r_cnt == '0);

    // Every state entry reloads r_cnt; a zero count means "last cycle of this phase".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_set   <= 1'b0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_ctrl     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_op_set <= req_op[1];
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        if (op_legal(req_op)) begin
                            r_state    <= SETUP;
                            r_s        <= req_op[1];
                            r_r        <= req_op[0];
                            r_err_code <= ERR_NONE;
                        end else begin
                            r_state    <= FAIL;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_ILLEGAL;
                        end
                    end
                end
                SETUP: begin
                    r_state <= PULSE;
                    r_ctrl  <= 1'b1;
                    r_cnt   <= PULSE_LD;
                end
                PULSE: begin
                    if (w_cnt_zero) begin
                        // Drop enable and pins together; the latch holds once control falls.
                        r_state <= GAP;
                        r_ctrl  <= 1'b0;
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_cnt   <= GAP_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (w_cnt_zero) begin
                        r_state <= CHECK;
                        r_cnt   <= CHK_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (w_pass) begin
                        r_state <= OK;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_cnt_zero) begin
                        r_state    <= FAIL;
                        r_err      <= 1'b1;
                        r_err_code <= (w_q == w_qbar) ? ERR_INVALID : ERR_TIMEOUT;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                OK, FAIL: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_ctrl  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign s         = r_s;
    assign r         = r_r;
    assign control   = r_ctrl;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
